// File: rtl/counter_pkg.sv
// Shared definitions for the ripple-counter consumers: default width, PWM FSM states, duty clamp.
// Pure declarations; no state, no latency, no flow control.
package counter_pkg;

    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_t;

    // Duty is a high-time in cycles, so anything beyond one full period saturates.
    function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned width);
        int unsigned max_duty;
        max_duty = 32'd1 << width;
        return (duty > max_duty) ? max_duty : duty;
    endfunction

endpackage

// File: rtl/wrap_detect.sv
// Flags the cycle where the counter rolls from all-ones to zero; combinational on count_in, one register of history.
// No flow control; a non-sequential jump to zero is not reported as a wrap.
module wrap_detect
    import counter_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         res,
    input  logic [W-1:0] count_in,
    output logic         wrap
);

    logic [W-1:0] prev_q;

    // Resetting to zero (not all-ones) keeps the first post-reset zero from looking like a wrap.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            prev_q <= '0;
        end else begin
            prev_q <= count_in;
        end
    end

    assign wrap = (count_in == '0) && (prev_q == '1);

endmodule

// File: rtl/counter_pwm_gen.sv
// Turns the free-running counter value into a registered PWM plus per-period pulse; count_in to pwm_out is 1 cycle.
// Single-slot duty buffer: duty_ready drops on accept and returns when the value is applied at the next running wrap.
module counter_pwm_gen #(
    parameter int WIDTH = counter_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] count_in,
    input  logic             en,
    input  logic             duty_valid,
    input  logic [WIDTH:0]   duty_data,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_done,
    output logic             running
);

    import counter_pkg::*;

    state_t           state;
    logic             wrap;
    logic [WIDTH:0]   pending_q;
    logic             pending_vld;
    logic [WIDTH:0]   active_q;
    logic [WIDTH:0]   d_eff;
    logic [WIDTH:0]   duty_clamped;
    logic             accept;
    logic             cmp_hi;

    wrap_detect #(
        .W(WIDTH)
    ) u_wrap_detect (
        .clk      (clk),
        .res      (res),
        .count_in (count_in),
        .wrap     (wrap)
    );

    assign duty_ready   = !pending_vld;
    assign accept       = duty_valid && duty_ready;
    assign duty_clamped = (WIDTH+1)'(clamp_duty(32'(duty_data), WIDTH));

    // On the wrap cycle the pending value is already the duty of the period that starts now.
    assign d_eff  = (wrap && pending_vld) ? pending_q : active_q;
    assign cmp_hi = ({1'b0, count_in} < d_eff);

    assign running = (state == RUN);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state       <= IDLE;
            pending_q   <= '0;
            pending_vld <= 1'b0;
            active_q    <= '0;
            pwm_out     <= 1'b0;
            period_done <= 1'b0;
        end else begin
            period_done <= 1'b0;

            if (wrap && pending_vld && (state != IDLE)) begin
                active_q    <= pending_q;
                pending_vld <= 1'b0;
            end

            // Accept only fires with the slot empty, so it never collides with the transfer above.
            if (accept) begin
                pending_q   <= duty_clamped;
                pending_vld <= 1'b1;
            end

            case (state)
                IDLE: begin
                    pwm_out <= 1'b0;
                    if (en) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (!en) begin
                        state   <= IDLE;
                        pwm_out <= 1'b0;
                    end else if (wrap) begin
                        state   <= RUN;
                        pwm_out <= (d_eff != '0);
                    end else begin
                        pwm_out <= 1'b0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state   <= IDLE;
                        pwm_out <= 1'b0;
                    end else begin
                        pwm_out     <= cmp_hi;
                        period_done <= wrap;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pwm_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_pwm_gen.sv
// Bench for counter_pwm_gen: rule-level model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_counter_pwm_gen;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic [3:0] count_in = 4'd0;
    logic       en = 1'b0;
    logic       duty_valid = 1'b0;
    logic [4:0] duty_data = 5'd0;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_done;
    logic       running;

    int total = 0;
    int bad = 0;
    int jump_req = 0;

    counter_pwm_gen #(.WIDTH(4)) dut (
        .clk         (clk),
        .res         (res),
        .count_in    (count_in),
        .en          (en),
        .duty_valid  (duty_valid),
        .duty_data   (duty_data),
        .duty_ready  (duty_ready),
        .pwm_out     (pwm_out),
        .period_done (period_done),
        .running     (running)
    );

    initial forever #5 clk = ~clk;

    // Free-running counter; a jump request forces a non-sequential return to zero.
    initial begin
        int seen;
        seen = 0;
        forever begin
            @(negedge clk);
            if (jump_req != seen) begin
                seen = jump_req;
                count_in = 4'd0;
            end else begin
                count_in = count_in + 4'd1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = stopped, 1 = waiting for first rollover, 2 = producing PWM.
    int m_mode = 0;
    int m_prev = 0;
    int m_active = 0;
    int m_pend[$];
    int exp_pwm = 0;
    int exp_pd = 0;

    always @(posedge clk) begin
        int  c;
        int  deff;
        bit  rolled;
        bit  take;
        bit  xfer;
        if (res) begin
            m_mode = 0;
            m_prev = 0;
            m_active = 0;
            m_pend.delete();
            exp_pwm = 0;
            exp_pd = 0;
        end else begin
            c = int'(count_in);
            rolled = (c == 0) && (m_prev == 15);
            m_prev = c;
            deff = (rolled && m_pend.size() > 0) ? m_pend[0] : m_active;
            take = duty_valid && (m_pend.size() == 0);
            xfer = rolled && (m_pend.size() > 0) && (m_mode != 0);
            exp_pd = 0;
            if (m_mode == 0) begin
                exp_pwm = 0;
                if (en) m_mode = 1;
            end else if (!en) begin
                m_mode = 0;
                exp_pwm = 0;
            end else if (m_mode == 1) begin
                if (rolled) begin
                    m_mode = 2;
                    exp_pwm = (deff > 0) ? 1 : 0;
                end else begin
                    exp_pwm = 0;
                end
            end else begin
                exp_pwm = (c < deff) ? 1 : 0;
                exp_pd = rolled ? 1 : 0;
            end
            if (xfer) m_active = m_pend.pop_front();
            if (take) m_pend.push_back((int'(duty_data) > 16) ? 16 : int'(duty_data));
        end
        #1;
        chk("pwm_out", int'(pwm_out), exp_pwm);
        chk("period_done", int'(period_done), exp_pd);
        chk("running", int'(running), (m_mode == 2) ? 1 : 0);
        chk("duty_ready", int'(duty_ready), (m_pend.size() == 0) ? 1 : 0);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic window(input string name, input int exp);
        int hi;
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #1;
            hi += int'(pwm_out);
        end
        chk(name, hi, exp);
    endtask

    task automatic wait_count(input int v);
        int n;
        n = 0;
        while (int'(count_in) != v && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 40) chk("wait_count_timeout", int'(count_in), v);
    endtask

    task automatic wait_running();
        int n;
        n = 0;
        while (!running && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 60) chk("wait_running_timeout", int'(running), 1);
    endtask

    // Presents a duty value and returns just after the edge that accepted it.
    task automatic send_duty(input int val, input bit keep);
        int n;
        n = 0;
        duty_valid = 1'b1;
        duty_data = 5'(val);
        while (!duty_ready && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 60) chk("send_timeout", int'(duty_ready), 1);
        @(posedge clk);
        #1;
        if (!keep) duty_valid = 1'b0;
    endtask

    initial begin
        int pd_cnt;
        #1;
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_period_done", int'(period_done), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_ready", int'(duty_ready), 1);
        cycles(3);
        res = 1'b0;

        // Basic PWM, duty loaded while stopped.
        send_duty(5, 1'b0);
        chk("idle_pending_held", int'(duty_ready), 0);
        en = 1'b1;
        wait_running();
        cycles(2);
        window("basic_high5", 5);
        pd_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            #1;
            pd_cnt += int'(period_done);
        end
        chk("basic_pd_per_32", pd_cnt, 2);

        // Glitch-free update mid-period.
        wait_count(7);
        send_duty(12, 1'b0);
        chk("update_ready_low", int'(duty_ready), 0);
        cycles(12);
        window("update_high12", 12);

        // Extremes and clamp.
        send_duty(0, 1'b0);
        cycles(40);
        window("duty0_low", 0);
        send_duty(16, 1'b0);
        cycles(40);
        window("duty16_high", 16);
        send_duty(31, 1'b0);
        cycles(40);
        window("duty31_clamped", 16);

        // Asynchronous reset while the output is high and a value is pending.
        send_duty(7, 1'b0);
        wait_count(5);
        res = 1'b1;
        #1;
        chk("async_rst_pwm", int'(pwm_out), 0);
        chk("async_rst_running", int'(running), 0);
        chk("async_rst_ready", int'(duty_ready), 1);
        chk("async_rst_pd", int'(period_done), 0);
        cycles(2);
        res = 1'b0;
        send_duty(16, 1'b0);
        chk("rearm_not_running", int'(running), 0);
        wait_running();
        cycles(2);
        window("rearm_high16", 16);

        // Accept on the wrap cycle goes to the following wrap.
        send_duty(5, 1'b0);
        cycles(40);
        wait_count(0);
        send_duty(3, 1'b0);
        cycles(8);
        chk("simul_still_pending", int'(duty_ready), 0);
        cycles(20);
        window("simul_applied3", 3);

        // Dropping en on a wrap cycle.
        wait_count(0);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_en_running", int'(running), 0);
        chk("drop_en_pwm", int'(pwm_out), 0);
        chk("drop_en_pd", int'(period_done), 0);

        // Back-to-back values with valid held high.
        en = 1'b1;
        wait_running();
        send_duty(9, 1'b1);
        send_duty(2, 1'b0);
        chk("b2b_second_pending", int'(duty_ready), 0);
        cycles(40);
        window("b2b_high2", 2);

        // Random traffic: en toggles, duty offers, counter jumps, reset pulses.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 99) < 2) en = ~en;
            duty_valid = ($urandom_range(0, 3) == 0);
            duty_data = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 199) == 0) jump_req++;
            if ($urandom_range(0, 399) == 0) begin
                res = 1'b1;
                #1;
                chk("rand_rst_pwm", int'(pwm_out), 0);
                chk("rand_rst_running", int'(running), 0);
                @(negedge clk);
                #1;
                res = 1'b0;
            end
        end
        duty_valid = 1'b0;
        cycles(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/counter_pwm_gen.md
# counter_pwm_gen

Downstream consumer of the 4-bit ripple counter (full adder + d_ff chain). Samples the free-running count each cycle and turns it into a registered PWM waveform, plus a per-period pulse. Duty values arrive over a valid/ready handshake and take effect only at counter wrap, so there are no glitched periods. Sits between the counter and any LED/driver output stage.

## Interface
- WIDTH, 4, counter width; period = 2^WIDTH cycles
- clk  in  1  rising-edge clock, same as counter
- res  in  1  asynchronous, active-high reset
- count_in  in  WIDTH  current counter value (counter's d_ff outputs)
- en  in  1  run request; level-sensitive
- duty_valid  in  1  duty_data is valid this cycle
- duty_data  in  WIDTH+1  requested high-time in cycles, 0..2^WIDTH
- duty_ready  out  1  pending slot empty; can accept a duty value
- pwm_out  out  1  registered PWM output
- period_done  out  1  one-cycle pulse per completed period while running
- running  out  1  FSM is in RUN

## Operation
- Wrap detect: prev_q registers count_in every cycle. wrap = (count_in == 0) && (prev_q == 2^WIDTH-1). prev_q resets to 0, so no false wrap after reset.
- Duty path: two registers, pending_q (plus pending_vld) and active_q.
  - Accept when duty_valid && duty_ready. duty_ready = !pending_vld.
  - duty_data > 2^WIDTH is clamped to 2^WIDTH on accept.
  - On wrap in ARM or RUN with pending_vld: active_q <= pending_q and pending_vld cleared.
  - Accept and wrap in the same cycle with the slot empty: the value goes to pending and is applied at the following wrap, not this one.
  - Accepts are allowed in every state, including IDLE.
- Effective duty d_eff = (wrap && pending_vld) ? pending_q : active_q.
- FSM states are IDLE, ARM and RUN.
  - IDLE: pwm_out <= 0. Moves to ARM when en=1.
  - ARM: pwm_out <= 0. Waits for wrap, then moves to RUN. On that wrap cycle pwm_out <= (0 < d_eff).
  - RUN: pwm_out <= (count_in < d_eff).
  - From ARM or RUN, en=0 moves to IDLE and forces pwm_out <= 0 the same edge. en has priority over wrap.
- period_done <= 1 on the edge after a cycle that is in RUN with wrap=1 and en=1. It is never asserted for the arming wrap.
- Duty 0 keeps pwm_out low for the whole period. Duty 2^WIDTH keeps it high for the whole period.

## Timing
- All outputs are registered except duty_ready, which is combinational from pending_vld.
- count_in to pwm_out latency is 1 cycle.
- A new duty value appears on pwm_out at the first wrap after the accept cycle, plus 1 cycle.
- Reset values: pwm_out=0, period_done=0, running=0, duty_ready=1. State IDLE, active_q=0, pending_vld=0, prev_q=0.
- Reset asserted mid-period drops pwm_out to 0 immediately (asynchronous). After release, the block re-arms and waits for a full wrap.
- count_in is assumed to increment by 1 per cycle. A non-sequential jump (for example counter reset) is not a wrap. pwm_out still follows the compare rule in RUN.

## Structure
- Shared package counter_pkg holds:
  - WIDTH default constant
  - state typedef enum {IDLE, ARM, RUN}
  - function clamp_duty
- Sub-module: wrap_detect, containing prev_q and the wrap compare. The counter testbench reuses it.
- Everything else stays flat: FSM, duty registers and compare.

## Test plan
- Reset: hold res=1 mid-stream. Expect pwm_out=0, period_done=0, running=0, duty_ready=1 asynchronously. After release with en=1, no pwm high until after count 15->0.
- Basic PWM: accept duty=5, en=1, counter free-running. After arming, each period pwm_out is high for counts 0..4 (5 cycles, 1-cycle delayed), and period_done pulses once every 16 cycles.
- Glitch-free update: while running duty=5, accept duty=12 at count 7. The current period stays at 5 high cycles, the next period has 12. duty_ready=0 from the accept cycle until the wrap.
- Extremes and clamp: duty=0 gives pwm_out constantly 0. duty=16 gives constantly 1. duty=31 is clamped, so it behaves like 16.
- Simultaneous events: accept duty=3 on the wrap cycle with the slot empty. It is applied at the following wrap. Drop en on a wrap cycle: IDLE next edge, pwm_out=0, no period_done.
- Handshake backpressure: duty_valid held high with two values back-to-back. The second is not accepted (ready=0) until the first is transferred at wrap, and there is no loss or duplication.
